// File: rtl/matrix_scan_ctrl.sv
// Column-multiplexed refresh controller for a 7x5 LED matrix with a
// double-buffered frame that is swapped only at the frame boundary.
module matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [34:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [6:0]  acender_coluna,
    output logic [4:0]  saida_reg,
    output logic        frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]       COL_LAST   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        col_q, col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [34:0]       active_q, active_d;
    logic [34:0]       shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              frame_ready_q, frame_ready_d;
    logic [6:0]        acender_q, acender_d;
    logic [4:0]        saida_q, saida_d;
    logic              frame_tick_q, frame_tick_d;
    logic              load, swap;

    function automatic logic [4:0] col_rows(input logic [34:0] frame, input logic [2:0] col);
        logic [5:0] base;
        base = 6'(col) * 6'd5;
        return frame[base +: 5];
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q + CNT_W'(1);

        // frame_ready is ~pending, so a load and a swap never coincide
        load      = frame_valid & frame_ready_q;
        swap      = frame_tick_q & pending_q;
        active_d  = swap ? shadow_q : active_q;
        shadow_d  = load ? frame_data : shadow_q;
        pending_d = load ? 1'b1 : (swap ? 1'b0 : pending_q);
        frame_ready_d = ~pending_d;

        if (!enable) begin
            state_d = S_IDLE;
            col_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;
                    col_d   = '0;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;
                        col_d   = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered from the next-state view so they line up with the state they describe
        acender_d    = '0;
        saida_d      = '0;
        frame_tick_d = 1'b0;
        if (state_d == S_DRIVE) begin
            acender_d    = 7'b000_0001 << col_d;
            saida_d      = col_rows(active_d, col_d);
            frame_tick_d = (col_d == COL_LAST) && (cnt_d == DWELL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            cnt_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            frame_ready_q <= 1'b1;
            acender_q     <= '0;
            saida_q       <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            frame_ready_q <= frame_ready_d;
            acender_q     <= acender_d;
            saida_q       <= saida_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign frame_ready    = frame_ready_q;
    assign acender_coluna = acender_q;
    assign saida_reg      = saida_q;
    assign frame_tick     = frame_tick_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: a time-indexed scan model checked every cycle,
// plus directed scenarios pinned with hand-computed values.
module tb_matrix_scan_ctrl;

    localparam int D      = 4;
    localparam int B      = 1;
    localparam int PERIOD = B + D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [34:0] frame_data = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [6:0]  acender_coluna;
    logic [4:0]  saida_reg;
    logic        frame_tick;

    int compared = 0;
    int mismatched = 0;
    bit check_en = 1'b0;

    // Model state: t counts cycles since scanning (re)started, -1 while dark
    int          t = -1;
    logic [34:0] m_active = '0;
    logic [34:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    bit          m_ready = 1'b1;
    logic [6:0]  e_col = '0;
    logic [4:0]  e_row = '0;
    bit          e_tick = 1'b0;

    matrix_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .frame_data     (frame_data),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .acender_coluna (acender_coluna),
        .saida_reg      (saida_reg),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_for_col(input logic [6:0] want, input string name);
        int n = 0;
        while (acender_coluna !== want && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, 64'(acender_coluna), 64'(want));
    endtask

    task automatic wait_for_tick(input string name);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, 64'(frame_tick), 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = -1;
                m_active = '0;
                m_shadow = '0;
                m_pending = 1'b0;
                m_ready = 1'b1;
                e_col = '0;
                e_row = '0;
                e_tick = 1'b0;
            end else begin
                bit load;
                bit swap;
                int ph;
                int c;
                load = frame_valid && m_ready;
                swap = e_tick && m_pending;
                if (swap) begin
                    m_active = m_shadow;
                    m_pending = 1'b0;
                end
                if (load) begin
                    m_shadow = frame_data;
                    m_pending = 1'b1;
                end
                m_ready = !m_pending;
                t = enable ? t + 1 : -1;
                e_col = '0;
                e_row = '0;
                e_tick = 1'b0;
                if (t >= 0) begin
                    ph = t % PERIOD;
                    c  = (t / PERIOD) % 7;
                    if (ph >= B) begin
                        e_col  = 7'(1 << c);
                        e_row  = m_active[5*c +: 5];
                        e_tick = (ph == PERIOD - 1) && (c == 6);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (check_en && rst_n) begin
                compared++;
                if (acender_coluna !== e_col || saida_reg !== e_row ||
                    frame_tick !== e_tick || frame_ready !== m_ready ||
                    (acender_coluna & (acender_coluna - 7'd1)) !== 7'd0) begin
                    mismatched++;
                    $display("FAIL model t=%0d: col=%b row=%h tick=%b rdy=%b, required col=%b row=%h tick=%b rdy=%b",
                             t, acender_coluna, saida_reg, frame_tick, frame_ready,
                             e_col, e_row, e_tick, m_ready);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_col", 64'(acender_coluna), 64'd0);
        chk("reset_row", 64'(saida_reg), 64'd0);
        chk("reset_tick", 64'(frame_tick), 64'd0);
        chk("reset_ready", 64'(frame_ready), 64'd1);
        rst_n = 1'b1;
        check_en = 1'b1;
        repeat (2) @(negedge clk);

        // First tick lands on the 35th cycle after scanning starts
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        chk("first_tick_cycle", 64'(n), 64'd35);

        wait_for_col(7'b0000100, "reach_col3");
        @(negedge clk);
        frame_data  = 35'h4_2108_421F;
        frame_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("ready_drop", 64'(frame_ready), 64'd0);
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        frame_data  = 35'h7_FFFF_FFFF;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        frame_data  = '0;

        wait_for_tick("swap_tick");
        @(posedge clk);
        #2;
        chk("ready_back", 64'(frame_ready), 64'd1);
        wait_for_col(7'b0000001, "new_col1");
        chk("new_row1", 64'(saida_reg), 64'h1F);
        wait_for_col(7'b0000010, "new_col2");
        chk("new_row2", 64'(saida_reg), 64'h10);

        wait_for_col(7'b0001000, "reach_col4");
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #2;
        chk("disable_dark", 64'(acender_coluna), 64'd0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #2;
        chk("reenable_blank", 64'(acender_coluna), 64'd0);
        @(posedge clk);
        #2;
        chk("reenable_col1", 64'(acender_coluna), 64'd1);
        chk("reenable_row1", 64'(saida_reg), 64'h1F);

        wait_for_col(7'b0000100, "reach_col3_b");
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_col", 64'(acender_coluna), 64'd0);
        chk("async_row", 64'(saida_reg), 64'd0);
        chk("async_ready", 64'(frame_ready), 64'd1);
        chk("async_active", 64'(dut.active_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Refresh controller for the 7-column × 5-row LED matrix. Holds a double-buffered 35-bit frame and time-multiplexes it: one column at a time, with a one-hot column enable and the matching 5-bit row pattern. Its `acender_coluna` and `saida_reg` outputs feed the display switch/gating stage, which then drives the physical column and row lines. Frames are loaded through a valid/ready handshake and take effect only at a frame boundary, so the display never shows a torn frame.

## Interface
- `DWELL_CYCLES`, default 50000: clock cycles a column stays lit; must be ≥ 1.
- `BLANK_CYCLES`, default 4: all-off cycles before each column, for anti-ghosting; 0 means no blanking.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  scanning on when 1; when 0, the display is dark.
- `frame_data`  in  35  new frame; column c occupies bits [5c+4:5c]; bit r of that slice is row r+1.
- `frame_valid`  in  1  `frame_data` is valid.
- `frame_ready`  out  1  shadow buffer is free; a transfer happens on `frame_valid & frame_ready` at the rising edge.
- `acender_coluna`  out  7  one-hot column enable, active-high; bit c is column c+1.
- `saida_reg`  out  5  row pattern for the lit column; bit r maps to `saida_reg{r+1}`.
- `frame_tick`  out  1  one-cycle pulse marking the end of column 7's dwell.

## Operation
- Storage:
  - `active` (35 bits) is displayed.
  - `shadow` (35 bits) holds the frame being loaded.
  - `pending` (1 bit) marks a frame waiting in `shadow`.
  - `frame_ready` is a registered copy of ~`pending`.
- Load:
  - On a handshake, `shadow` ← `frame_data` and `pending` ← 1.
  - `frame_ready` drops on the next cycle.
  - `frame_valid` while `frame_ready`=0 is ignored; no capture occurs.
- Swap: on the cycle `frame_tick` is asserted, if `pending`=1 then `active` ← `shadow` and `pending` ← 0. `frame_ready` returns to 1 on the next cycle.
- A swap and a new load cannot happen in the same cycle, because `frame_ready`=0 whenever `pending`=1.
- States:
  - IDLE:
    - `acender_coluna`=0, `saida_reg`=0.
    - Column index `col`=0, dwell counter=0.
    - `enable`=1 → BLANK, or → DRIVE if `BLANK_CYCLES`=0.
  - BLANK:
    - Outputs 0.
    - Counts `BLANK_CYCLES` cycles, then → DRIVE.
  - DRIVE:
    - `acender_coluna` = 1<<`col`.
    - `saida_reg` = `active[5*col+4 : 5*col]`.
    - After `DWELL_CYCLES` cycles, `col` advances (6 wraps to 0) and the state goes → BLANK, or → DRIVE if `BLANK_CYCLES`=0.
    - On the last DRIVE cycle of `col`=6, `frame_tick`=1.
- `enable`=0 in any state → IDLE on the next edge.
  - Outputs go to 0 and `col` restarts at 0.
  - `active`, `shadow` and `pending` are preserved.
  - The load handshake keeps working while in IDLE.
  - No swap occurs in IDLE; a pending frame swaps at the first `frame_tick` after re-enable.
- Counter width is $clog2(max(`DWELL_CYCLES`, `BLANK_CYCLES`)+1). The counter resets to 0 on every state change.
- `acender_coluna` is never more than one-hot. The row pattern changes only together with the column, never while the column is lit.

## Timing
- All outputs are registered.
- Reset values:
  - `acender_coluna`=0, `saida_reg`=0, `frame_tick`=0.
  - `frame_ready`=1.
  - `active`=0, `shadow`=0, `pending`=0.
  - State IDLE.
- Reset asserted mid-scan forces the reset values immediately, without waiting for a clock edge.
- `enable` sampled 1 at edge k: the first blank cycle is k+1, and column 1 lights at k+1+`BLANK_CYCLES`.
- Column period is `BLANK_CYCLES`+`DWELL_CYCLES` cycles; frame period is 7× that.
- A swapped frame's column 1 appears at the first DRIVE cycle after `frame_tick`.
- `enable`=0 sampled at edge k: outputs are 0 from k+1.
- Load latency: a handshake at edge k gives `frame_ready`=0 from k+1.

## Test plan
Params `DWELL_CYCLES`=4, `BLANK_CYCLES`=1.
- Reset, then `enable`=1 with no load → `acender_coluna` follows 0, then 0000001×4, then 0, then 0000010×4, … up to 1000000×4; `saida_reg`=0 throughout; `frame_tick` pulses on the 35th cycle after scanning starts; the pattern repeats.
- Load `frame_data`=35'h4_2108_421F while scanning column 3 → `frame_ready`=0 next cycle; columns 3–7 still show 0; after `frame_tick`, column 1 shows 5'h1F and column 2 shows 5'h10; `frame_ready`=1 one cycle after the swap.
- Second `frame_valid` pulse while `pending`=1 → not captured; the displayed frame is the first load.
- `enable` dropped during column 4 DRIVE → outputs 0 the next cycle; on re-enable, the scan restarts at column 1 after 1 blank cycle.
- `rst_n` pulsed low mid-DRIVE, without a clock edge → outputs 0, `frame_ready`=1, `active`=0 immediately.
- Every cycle, check that `acender_coluna` is zero or one-hot.
